instr_encoder_writer: RTL and testbench

//  Encoder counterpart of the control-unit opcode decoder. Takes symbolic instructions (op, regs, imm, cond)

---
 rtl/instr_encoder_writer.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_writer.sv
// Packs symbolic instructions into 32-bit words and streams them into instruction memory.
// A finish request appends an all-zero END word (if room remains) and parks the block in DONE.
module instr_encoder_writer #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int SP_REG = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_cond,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    input  logic              finish,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic              full,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_INC = (ADDR_W+1)'(1);
    localparam logic [3:0]      SP      = 4'(SP_REG);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
    logic                ending_q, ending_d;

    logic [31:0] word;
    logic        legal;
    logic        imm_ok;
    logic [23:0] mag;
    logic [3:0]  cond_nib;

    assign imm_ok = (in_imm[23:12] == 12'h000);
    // Branch offset magnitude; -2**23 keeps bit 23 set and is rejected as out of range.
    assign mag    = in_imm[23] ? (~in_imm + 24'd1) : in_imm;

    always_comb begin
        cond_nib = 4'he;
        case (in_cond)
            3'd0:    cond_nib = 4'he;
            3'd1:    cond_nib = 4'h0;
            3'd2:    cond_nib = 4'h1;
            3'd3:    cond_nib = 4'hc;
            3'd4:    cond_nib = 4'hb;
            3'd5:    cond_nib = 4'ha;
            3'd6:    cond_nib = 4'hd;
            default: cond_nib = 4'he;
        endcase
    end

    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (in_op)
            4'd0:  begin word = {12'he1a, 4'h0, in_rd, 8'h00, in_rm}; legal = 1'b1; end
            4'd1:  begin word = {12'he3a, 4'h0, in_rd, in_imm[11:0]}; legal = imm_ok; end
            4'd2:  begin word = {12'he08, in_rn, in_rd, 8'h00, in_rm}; legal = 1'b1; end
            4'd3:  begin word = {12'he28, in_rn, in_rd, in_imm[11:0]}; legal = imm_ok; end
            4'd4:  begin word = {12'he04, in_rn, in_rd, 8'h00, in_rm}; legal = 1'b1; end
            4'd5:  begin word = {12'he24, in_rn, in_rd, in_imm[11:0]}; legal = imm_ok; end
            4'd6:  begin word = {12'he15, in_rn, 4'h0, 8'h00, in_rm}; legal = 1'b1; end
            4'd7:  begin word = {12'he35, in_rn, 4'h0, in_imm[11:0]}; legal = imm_ok; end
            4'd8:  begin word = {12'he59, in_rn, in_rd, in_imm[11:0]}; legal = imm_ok; end
            4'd9:  begin word = {12'he58, in_rn, in_rd, in_imm[11:0]}; legal = imm_ok; end
            4'd10: begin word = {12'he52, SP, in_rd, 12'd4}; legal = 1'b1; end
            4'd11: begin word = {12'he49, SP, in_rd, 12'd4}; legal = 1'b1; end
            4'd12: begin
                word  = {cond_nib, 4'ha, in_imm[23], mag[22:0]};
                legal = (in_cond != 3'd7) && !mag[23];
            end
            default: begin word = 32'h0; legal = 1'b0; end
        endcase
    end

    assign in_ready = (state_q == IDLE) && !full_q && !done_q;

    // Finish outranks a pending request; an accepted request never waits a second cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        full_d      = full_q;
        done_d      = done_q;
        ending_d    = ending_q;
        case (state_q)
            IDLE: begin
                if (finish) begin
                    if (!full_q) begin
                        mem_wdata_d = 32'h0;
                        mem_addr_d  = ptr_q[ADDR_W-1:0];
                        mem_we_d    = 1'b1;
                        ending_d    = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else if (in_valid && in_ready) begin
                    if (legal) begin
                        mem_wdata_d = word;
                        mem_addr_d  = ptr_q[ADDR_W-1:0];
                        mem_we_d    = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                ptr_d  = ptr_q + PTR_INC;
                full_d = ((ptr_q + PTR_INC) == DEPTH_P);
                if (ending_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            ending_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            full_q      <= full_d;
            done_q      <= done_d;
            ending_q    <= ending_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign full      = full_q;
    assign done      = done_q;
    assign count     = ptr_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed self-checking bench for instr_encoder_writer (DEPTH reduced to 4 so the full path is reachable).
module tb_instr_encoder_writer;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [2:0]        in_cond;
    logic [3:0]        in_rd;
    logic [3:0]        in_rn;
    logic [3:0]        in_rm;
    logic [23:0]       in_imm;
    logic              finish;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic              full;
    logic              done;
    logic [ADDR_W:0]   count;

    int total  = 0;
    int passed = 0;

    instr_encoder_writer #(.ADDR_W(ADDR_W), .DEPTH(4), .SP_REG(13)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_cond(in_cond), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .finish(finish), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .err(err), .full(full), .done(done), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        finish   = 1'b0;
        step();
        step();
    endtask

    // Present one request for exactly one edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] cond, input logic [3:0] rd,
                                 input logic [3:0] rn, input logic [3:0] rm, input logic [23:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_cond  = cond;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic writeAndCheck(input string tag, input logic [3:0] op, input logic [2:0] cond,
                                 input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                 input logic [23:0] imm, input logic [31:0] exp_word, input int exp_addr);
        applyStimulus(op, cond, rd, rn, rm, imm);
        checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        checkOutput({tag, "_wdata"}, mem_wdata, exp_word);
        checkOutput({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
        step();
        checkOutput({tag, "_count"}, 32'(count), 32'(exp_addr + 1));
        checkOutput({tag, "_we_off"}, 32'(mem_we), 32'd0);
    endtask

    logic [31:0] fill_words [4];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; finish = 1'b0;
        in_op = 4'd0; in_cond = 3'd0; in_rd = 4'd0; in_rn = 4'd0; in_rm = 4'd0; in_imm = 24'd0;
        fill_words[0] = 32'he3a0_00a0;
        fill_words[1] = 32'he3a0_10a1;
        fill_words[2] = 32'he3a0_20a2;
        fill_words[3] = 32'he3a0_30a3;

        // Reset values and first register-form encoding straight out of reset.
        doReset();
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        writeAndCheck("addr", 4'd2, 3'd0, 4'd2, 4'd1, 4'd3, 24'd0, 32'he081_2003, 0);

        // Branches: backward EQ and forward AL.
        doReset();
        rst_n = 1'b1;
        writeAndCheck("b_eq", 4'd12, 3'd1, 4'd0, 4'd0, 4'd0, 24'hff_fffb, 32'h0a80_0005, 0);
        writeAndCheck("b_al", 4'd12, 3'd0, 4'd0, 4'd0, 4'd0, 24'h00_0010, 32'hea00_0010, 1);

        // Stack ops, then rejected requests leave the pointer alone.
        doReset();
        rst_n = 1'b1;
        writeAndCheck("push", 4'd10, 3'd0, 4'd4, 4'd0, 4'd0, 24'd0, 32'he52d_4004, 0);
        writeAndCheck("pop", 4'd11, 3'd0, 4'd4, 4'd0, 4'd0, 24'd0, 32'he49d_4004, 1);
        applyStimulus(4'd1, 3'd0, 4'd1, 4'd0, 4'd0, 24'h00_1000);
        checkOutput("movi_big_err", 32'(err), 32'd1);
        checkOutput("movi_big_we", 32'(mem_we), 32'd0);
        checkOutput("movi_big_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("movi_big_err_pulse", 32'(err), 32'd0);
        checkOutput("movi_big_count", 32'(count), 32'd2);
        applyStimulus(4'd12, 3'd0, 4'd0, 4'd0, 4'd0, 24'h80_0000);
        checkOutput("b_min_err", 32'(err), 32'd1);
        applyStimulus(4'd12, 3'd7, 4'd0, 4'd0, 4'd0, 24'h00_0004);
        checkOutput("b_cond7_err", 32'(err), 32'd1);
        applyStimulus(4'd13, 3'd0, 4'd0, 4'd0, 4'd0, 24'h00_0000);
        checkOutput("op13_err", 32'(err), 32'd1);
        checkOutput("op13_we", 32'(mem_we), 32'd0);
        step();
        checkOutput("illegal_count", 32'(count), 32'd2);
        writeAndCheck("b_max", 4'd12, 3'd3, 4'd0, 4'd0, 4'd0, 24'h7f_ffff, 32'hca7f_ffff, 2);

        // Fill to DEPTH=4, finish while full ends without a write.
        doReset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            writeAndCheck("fill", 4'd1, 3'd0, 4'(i), 4'd0, 4'd0, 24'(12'h0a0 + i), fill_words[i], i);
        end
        checkOutput("full_flag", 32'(full), 32'd1);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        step();
        checkOutput("full_wait_err", 32'(err), 32'd0);
        checkOutput("full_wait_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        checkOutput("full_fin_done", 32'(done), 32'd1);
        checkOutput("full_fin_we", 32'(mem_we), 32'd0);
        checkOutput("full_fin_count", 32'(count), 32'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("done_ign_we", 32'(mem_we), 32'd0);
            checkOutput("done_ign_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        checkOutput("done_sticky", 32'(done), 32'd1);

        // finish together with in_valid after two words: END word wins.
        doReset();
        rst_n = 1'b1;
        writeAndCheck("pre0", 4'd0, 3'd0, 4'd5, 4'd0, 4'd6, 24'd0, 32'he1a0_5006, 0);
        writeAndCheck("pre1", 4'd6, 3'd0, 4'd0, 4'd7, 4'd8, 24'd0, 32'he157_0008, 1);
        finish = 1'b1;
        applyStimulus(4'd2, 3'd0, 4'd2, 4'd1, 4'd3, 24'd0);
        finish = 1'b0;
        checkOutput("end_we", 32'(mem_we), 32'd1);
        checkOutput("end_addr", 32'(mem_addr), 32'd2);
        checkOutput("end_wdata", mem_wdata, 32'h0000_0000);
        step();
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_count", 32'(count), 32'd3);
        checkOutput("end_we_off", 32'(mem_we), 32'd0);
        step();
        checkOutput("end_no_extra", 32'(mem_we), 32'd0);
        checkOutput("end_count_hold", 32'(count), 32'd3);

        // Reset arriving while the write strobe is up.
        doReset();
        rst_n = 1'b1;
        applyStimulus(4'd4, 3'd0, 4'd1, 4'd2, 4'd3, 24'd0);
        checkOutput("midw_we_pre", 32'(mem_we), 32'd1);
        checkOutput("midw_wdata_pre", mem_wdata, 32'he042_1003);
        rst_n = 1'b0;
        step();
        checkOutput("midw_we", 32'(mem_we), 32'd0);
        checkOutput("midw_count", 32'(count), 32'd0);
        checkOutput("midw_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        checkOutput("midw_idle", 32'(mem_we), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
